// File: rtl/delay_line_multi.sv
`default_nettype none
// ============================================================================
//  Module   : delay_line_multi
//  Brief    : CHANNELS-lane programmable sample delay line (1..DEPTH samples)
//             sharing one write pointer, with per-lane fill tracking.
//  Option   : DELAY_LINE_CNT_EN adds drop_cnt_o (per-lane suppressed pushes).
//  Revision : 1.0  initial release
// ============================================================================
module delay_line_multi #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 2
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            ena_i,
    input  logic                                            cfg_valid_i,
    output logic                                            cfg_ready_o,
    input  logic [$clog2((CHANNELS > 1) ? CHANNELS : 2)-1:0] cfg_chan_i,
    input  logic [$clog2(DEPTH):0]                          cfg_delay_i,
    output logic                                            cfg_err_o,
    input  logic                                            in_valid_i,
    input  logic [CHANNELS*WIDTH-1:0]                       in_data_i,
    output logic [CHANNELS-1:0]                             out_valid_o,
    output logic [CHANNELS*WIDTH-1:0]                       out_data_o
`ifdef DELAY_LINE_CNT_EN
    ,
    output logic [CHANNELS*16-1:0]                          drop_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int AW = PW + 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [AW-1:0] DEPTH_V = AW'(DEPTH);

    typedef enum logic {
        ST_FILLING = 1'b0,
        ST_RUN     = 1'b1
    } lane_state_e;

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic                cfg_ready_q;
    logic                cfg_err_q, cfg_err_d;
    logic                w_push;
    logic                w_cfg_acc;
    logic                w_cfg_legal;
    logic [CHANNELS-1:0] w_cfg_hit;

    assign w_push      = in_valid_i & ena_i;
    assign w_cfg_acc   = cfg_valid_i & cfg_ready_q & ena_i;
    assign w_cfg_legal = (cfg_delay_i != '0) && (cfg_delay_i <= DEPTH_V)
                         && (int'(cfg_chan_i) < CHANNELS);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cfg_err_d = cfg_err_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (w_cfg_acc && !w_cfg_legal) begin
            cfg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            cfg_ready_q <= ena_i;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign cfg_err_o   = cfg_err_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]    delay_q, delay_d;
        logic [AW-1:0]    fill_q, fill_d;
        logic             out_valid_q, out_valid_d;
        logic [WIDTH-1:0] out_data_q, out_data_d;
        logic [PW-1:0]    w_rd;
        logic [WIDTH-1:0] w_din;
        lane_state_e      w_state;

        assign w_din     = in_data_i[c*WIDTH +: WIDTH];
        assign w_cfg_hit[c] = w_cfg_acc && w_cfg_legal && (cfg_chan_i == CW'(c));
        // A delay of DEPTH aliases to rd == wr_ptr: the oldest entry is read before it is overwritten.
        assign w_rd      = wr_ptr_q - delay_q[PW-1:0];
        assign w_state   = (fill_q >= delay_q) ? ST_RUN : ST_FILLING;

        always_comb begin
            delay_d     = delay_q;
            fill_d      = fill_q;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            if (w_push) begin
                out_valid_d = (w_state == ST_RUN);
                out_data_d  = mem_q[w_rd];
                if (fill_q != DEPTH_V) begin
                    fill_d = fill_q + AW'(1);
                end
            end
            // The push in the same cycle still used the old delay; it counts as the first new fill.
            if (w_cfg_hit[c]) begin
                delay_d = cfg_delay_i;
                fill_d  = w_push ? AW'(1) : '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                delay_q     <= AW'(1);
                fill_q      <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                delay_q     <= delay_d;
                fill_q      <= fill_d;
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= w_din;
            end
        end

        assign out_valid_o[c]                 = out_valid_q;
        assign out_data_o[c*WIDTH +: WIDTH]   = out_data_q;

`ifdef DELAY_LINE_CNT_EN
        logic [15:0] drop_q, drop_d;

        always_comb begin
            drop_d = drop_q;
            if (w_push && (w_state == ST_FILLING) && (drop_q != 16'hFFFF)) begin
                drop_d = drop_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drop_q <= '0;
            end else begin
                drop_q <= drop_d;
            end
        end

        assign drop_cnt_o[c*16 +: 16] = drop_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_line_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delay_line_multi
//  Brief    : Randomised self-checking bench for delay_line_multi against a
//             sample-history reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_delay_line_multi;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CH = 2;
    localparam int AW = $clog2(D) + 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int DW = CH * W;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          ena_i       = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic [CW-1:0] cfg_chan_i  = '0;
    logic [AW-1:0] cfg_delay_i = '0;
    logic          in_valid_i  = 1'b0;
    logic [DW-1:0] in_data_i   = '0;
    logic          cfg_ready_o;
    logic          cfg_err_o;
    logic [CH-1:0] out_valid_o;
    logic [DW-1:0] out_data_o;
`ifdef DELAY_LINE_CNT_EN
    logic [CH*16-1:0] drop_cnt_o;
`endif

    always #5 clk = ~clk;

    delay_line_multi #(
        .WIDTH    (W),
        .DEPTH    (D),
        .CHANNELS (CH)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena_i       (ena_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_chan_i  (cfg_chan_i),
        .cfg_delay_i (cfg_delay_i),
        .cfg_err_o   (cfg_err_o),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o)
`ifdef DELAY_LINE_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: every pushed word, plus per-lane delay and pushes since (re)configuration.
    logic [DW-1:0] hist [$];
    int            m_delay [CH];
    int            m_since [CH];
    int            m_drop  [CH];
    bit            m_ready;
    bit            m_err;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_delay[c] = 1;
            m_since[c] = 0;
            m_drop[c]  = 0;
        end
        m_ready = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n       = 1'b0;
        ena_i       = 1'b0;
        cfg_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid_o, '0);
        check_eq("rst_out_data", out_data_o, '0);
        check_eq("rst_cfg_err", cfg_err_o, '0);
        check_eq("rst_cfg_ready", cfg_ready_o, '0);
`ifdef DELAY_LINE_CNT_EN
        check_eq("rst_drop_cnt", drop_cnt_o, '0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    // One clock: apply inputs, predict from the model, then compare after the edge.
    task automatic step(input bit en, input bit cv, input int ch, input int dl,
                        input bit iv, input logic [DW-1:0] dat);
        logic [CH-1:0] ev;
        logic [W-1:0]  ed [CH];
        bit            push, acc, legal;
        int            che;
        ena_i       = en;
        cfg_valid_i = cv;
        cfg_chan_i  = CW'(ch);
        cfg_delay_i = AW'(dl);
        in_valid_i  = iv;
        in_data_i   = dat;
        push  = iv && en;
        acc   = cv && m_ready && en;
        che   = ch % (1 << CW);
        legal = (dl >= 1) && (dl <= D) && (che < CH);
        ev    = '0;
        for (int c = 0; c < CH; c++) begin
            ed[c] = '0;
            if (push && m_since[c] >= m_delay[c]) begin
                ev[c] = 1'b1;
                ed[c] = hist[hist.size() - m_delay[c]][c*W +: W];
            end
            if (push && m_since[c] < m_delay[c] && m_drop[c] < 65535) m_drop[c]++;
        end
        if (push) begin
            hist.push_back(dat);
            for (int c = 0; c < CH; c++) m_since[c] = (m_since[c] < D) ? m_since[c] + 1 : D;
        end
        if (acc) begin
            if (legal) begin
                m_delay[che] = dl;
                m_since[che] = push ? 1 : 0;
            end else begin
                m_err = 1'b1;
            end
        end
        m_ready = en;
        @(posedge clk);
        #1;
        check_eq("out_valid", out_valid_o, ev);
        for (int c = 0; c < CH; c++) begin
            if (ev[c]) check_eq($sformatf("out_data%0d", c), out_data_o[c*W +: W], ed[c]);
`ifdef DELAY_LINE_CNT_EN
            check_eq($sformatf("drop_cnt%0d", c), drop_cnt_o[c*16 +: 16], m_drop[c]);
`endif
        end
        check_eq("cfg_err", cfg_err_o, m_err);
        check_eq("cfg_ready", cfg_ready_o, m_ready);
    endtask

    function automatic logic [DW-1:0] rep(input int k);
        return {CH{W'(k)}};
    endfunction

    initial begin
        model_reset();
        async_reset();
        step(1, 0, 0, 0, 0, '0);

        // Default delay of 1
        step(1, 0, 0, 0, 1, rep(8'h11));
        step(1, 0, 0, 0, 1, rep(8'h22));
        step(1, 0, 0, 0, 1, rep(8'h33));
        check_eq("d1_lane0_data", out_data_o[W-1:0], 8'h22);

        // Lane0 d=16, lane1 d=3; reconfigure lane1 to 5 on push 20
        step(1, 1, 0, 16, 0, '0);
        step(1, 1, 1, 3, 0, '0);
        for (int k = 0; k < 40; k++) step(1, (k == 20), 1, 5, 1, rep(k));

        // Illegal delays raise a sticky error without touching the streams
        step(1, 1, 0, 0, 1, rep(40));
        step(1, 1, 1, 17, 1, rep(41));
        for (int k = 42; k < 46; k++) step(1, 0, 0, 0, 1, rep(k));
        check_eq("err_sticky", cfg_err_o, 1'b1);

        // Tile disabled while data is offered
        for (int k = 0; k < 4; k++) step(0, 1, 0, 2, 1, rep(8'hE0 + k));
        for (int k = 46; k < 52; k++) step(1, 0, 0, 0, 1, rep(k));

        // Drop counting from reset with d=4, then reconfigure
        async_reset();
        step(1, 0, 0, 0, 0, '0);
        step(1, 1, 0, 4, 0, '0);
        step(1, 1, 1, 4, 0, '0);
        for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 1, rep(k + 8'h60));
`ifdef DELAY_LINE_CNT_EN
        check_eq("drop_lane0_eq4", drop_cnt_o[15:0], 16'd4);
        step(1, 1, 0, 2, 0, '0);
        check_eq("drop_kept", drop_cnt_o[15:0], 16'd4);
`endif

        // Random traffic, mid-stream reset, more random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, CH - 1),
                 $urandom_range(0, D + 2), $urandom_range(0, 3) != 0, DW'($urandom));
        end
        async_reset();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, CH - 1),
                 $urandom_range(1, D), $urandom_range(0, 2) != 0, DW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
